// File: rtl/reg_dump_streamer_if.sv
// Valid/ready word stream carrying one register number and value per beat.
interface reg_dump_streamer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] reg_num;
    logic [DATA_W-1:0] data;

    modport master (
        output valid,
        output reg_num,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  reg_num,
        input  data,
        output ready
    );
endinterface

// File: rtl/reg_dump_streamer.sv
// Walks a register range through a spare regfile read port and streams each word.
// Optional REG_DUMP_CHECKSUM_EN appends an XOR checksum word (reg_num 0) to each dump.
module reg_dump_streamer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                dump_start,
    input  logic [ADDR_W-1:0]   dump_first,
    input  logic [ADDR_W-1:0]   dump_last,
    output logic [ADDR_W-1:0]   rf_read_addr,
    input  logic [DATA_W-1:0]   rf_read_data,
    output logic                dump_busy,
    output logic                dump_done,
    reg_dump_streamer_if.master dump
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_PRESENT,
`ifdef REG_DUMP_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] cur_q;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] num_q;
    logic [DATA_W-1:0] data_q;
    logic              valid;
    logic              hs;
    logic              at_last;

    assign hs      = valid & dump.ready;
    assign at_last = (cur_q == last_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        valid     = 1'b0;
        dump_busy = 1'b1;
        dump_done = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                dump_busy = 1'b0;
                if (dump_start) state_d = S_READ;
            end
            S_READ: begin
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                valid = 1'b1;
                if (dump.ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
                    state_d = at_last ? S_CSUM : S_READ;
`else
                    state_d = at_last ? S_DONE : S_READ;
`endif
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            S_CSUM: begin
                valid = 1'b1;
                if (dump.ready) state_d = S_DONE;
            end
`endif
            S_DONE: begin
                dump_busy = 1'b0;
                dump_done = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                dump_busy = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] acc_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else if (state_q == S_IDLE && dump_start) begin
            acc_q <= '0;
        end else if (state_q == S_PRESENT && hs) begin
            acc_q <= acc_q ^ data_q;
        end
    end
`endif

    // cur advances only on a non-final handshake, so it ends parked on last
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_q  <= '0;
            last_q <= '0;
            num_q  <= '0;
            data_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (dump_start) begin
                        cur_q  <= dump_first;
                        last_q <= dump_last;
                    end
                end
                S_READ: begin
                    data_q <= rf_read_data;
                    num_q  <= cur_q;
                end
                S_PRESENT: begin
                    if (hs) begin
                        if (!at_last) begin
                            cur_q <= cur_q + ADDR_W'(1);
                        end
`ifdef REG_DUMP_CHECKSUM_EN
                        else begin
                            data_q <= acc_q ^ data_q;
                            num_q  <= '0;
                        end
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rf_read_addr = cur_q;
    assign dump.valid   = valid;
    assign dump.reg_num = num_q;
    assign dump.data    = data_q;

endmodule
